// File: rtl/demux1to4_nbit_buffered.sv
// demux1to4_nbit_buffered: registered 1-to-4 valid/ready demux with one-word buffer per channel
module demux1to4_nbit_buffered #(
    parameter int N     = 16,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_sel,
    input  logic [N-1:0]     in_data,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [N-1:0]     out_data0,
    output logic [N-1:0]     out_data1,
    output logic [N-1:0]     out_data2,
    output logic [N-1:0]     out_data3,
    output logic [CNT_W-1:0] accept_cnt
);
    logic [N-1:0] buf_q [4];
    logic         accept;
    always_comb begin
        in_ready = ~out_valid[in_sel] | out_ready[in_sel];
        accept   = in_valid & in_ready;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid  <= '0;
            accept_cnt <= '0;
            for (int k = 0; k < 4; k++) buf_q[k] <= '0;
        end else begin
            accept_cnt <= accept_cnt + CNT_W'(accept);
            for (int k = 0; k < 4; k++) begin
                if (accept && in_sel == 2'(k)) begin
                    out_valid[k] <= 1'b1;
                    buf_q[k]     <= in_data;
                end else if (out_ready[k]) begin
                    out_valid[k] <= 1'b0;
                end
            end
        end
    end
    assign out_data0 = buf_q[0];
    assign out_data1 = buf_q[1];
    assign out_data2 = buf_q[2];
    assign out_data3 = buf_q[3];
endmodule

// File: tb/tb_demux1to4_nbit_buffered.sv
// tb_demux1to4_nbit_buffered: directed-vector bench for the buffered 1-to-4 demux
module tb_demux1to4_nbit_buffered;
    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_sel;
    logic [15:0] in_data;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [15:0] out_data0, out_data1, out_data2, out_data3;
    logic [3:0]  accept_cnt;
    logic [15:0] exp_data [4];
    int          n_cmp = 0;
    int          n_bad = 0;

    demux1to4_nbit_buffered #(.N(16), .CNT_W(4)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_sel(in_sel), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data0(out_data0), .out_data1(out_data1), .out_data2(out_data2),
        .out_data3(out_data3), .accept_cnt(accept_cnt)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [15:0] od(input int k);
        return k == 0 ? out_data0 : k == 1 ? out_data1 : k == 2 ? out_data2 : out_data3;
    endfunction

    task automatic put(input logic v, input logic [1:0] s, input logic [15:0] d);
        in_valid = v;
        in_sel   = s;
        in_data  = d;
    endtask

    initial begin
        reset = 1'b1;
        out_ready = 4'b0000;
        put(1'b0, 2'd0, 16'h0);
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_d0", 32'(out_data0), 32'h0);
        chk("rst_d3", 32'(out_data3), 32'h0);
        chk("rst_cnt", 32'(accept_cnt), 32'h0);
        chk("rst_ready", 32'(in_ready), 32'h1);

        put(1'b1, 2'd2, 16'hBEEF);
        tick();
        chk("t1_valid", 32'(out_valid), 32'h4);
        chk("t1_d2", 32'(out_data2), 32'hBEEF);
        chk("t1_cnt", 32'(accept_cnt), 32'h1);

        put(1'b1, 2'd2, 16'h1234);
        #1;
        chk("t2_stall_ready", 32'(in_ready), 32'h0);
        tick();
        chk("t2_hold_d2", 32'(out_data2), 32'hBEEF);
        chk("t2_hold_cnt", 32'(accept_cnt), 32'h1);
        chk("t2_hold_valid", 32'(out_valid), 32'h4);
        put(1'b1, 2'd0, 16'h1234);
        #1;
        chk("t2_other_ready", 32'(in_ready), 32'h1);
        tick();
        chk("t2_valid", 32'(out_valid), 32'h5);
        chk("t2_d0", 32'(out_data0), 32'h1234);
        chk("t2_d2_kept", 32'(out_data2), 32'hBEEF);
        chk("t2_cnt", 32'(accept_cnt), 32'h2);

        put(1'b1, 2'd1, 16'hAAAA);
        tick();
        chk("t3_fill_valid", 32'(out_valid), 32'h7);
        chk("t3_fill_d1", 32'(out_data1), 32'hAAAA);
        out_ready = 4'b0010;
        put(1'b1, 2'd1, 16'h5555);
        #1;
        chk("t3_b2b_ready", 32'(in_ready), 32'h1);
        tick();
        chk("t3_b2b_valid", 32'(out_valid), 32'h7);
        chk("t3_b2b_d1", 32'(out_data1), 32'h5555);
        chk("t3_b2b_cnt", 32'(accept_cnt), 32'h4);
        for (int i = 1; i <= 4; i++) begin
            put(1'b1, 2'd1, 16'(i));
            tick();
            chk("t3_stream_d1", 32'(out_data1), 32'(i));
            chk("t3_stream_v1", 32'(out_valid[1]), 32'h1);
        end
        chk("t3_cnt", 32'(accept_cnt), 32'h8);
        put(1'b0, 2'd1, 16'hFFFF);
        tick();
        chk("t3_drain_valid", 32'(out_valid), 32'h5);
        chk("t3_drain_d1", 32'(out_data1), 32'h4);

        out_ready = 4'b0000;
        put(1'b1, 2'd1, 16'h1111);
        tick();
        put(1'b1, 2'd3, 16'h3333);
        tick();
        chk("t4_full", 32'(out_valid), 32'hF);
        chk("t4_cnt_full", 32'(accept_cnt), 32'hA);
        out_ready = 4'b1111;
        put(1'b0, 2'bxx, 16'hxxxx);
        tick();
        chk("t4_valid", 32'(out_valid), 32'h0);
        chk("t4_d0", 32'(out_data0), 32'h1234);
        chk("t4_d1", 32'(out_data1), 32'h1111);
        chk("t4_d2", 32'(out_data2), 32'hBEEF);
        chk("t4_d3", 32'(out_data3), 32'h3333);
        chk("t4_cnt", 32'(accept_cnt), 32'hA);

        out_ready = 4'b0000;
        put(1'b1, 2'd0, 16'hC0C0);
        tick();
        put(1'b1, 2'd3, 16'h3C3C);
        tick();
        chk("t5_pre_valid", 32'(out_valid), 32'h9);
        chk("t5_pre_cnt", 32'(accept_cnt), 32'hC);
        reset = 1'b1;
        put(1'b1, 2'd1, 16'hDEAD);
        tick();
        reset = 1'b0;
        put(1'b0, 2'd0, 16'h0);
        #1;
        chk("t5_valid", 32'(out_valid), 32'h0);
        chk("t5_d0", 32'(out_data0), 32'h0);
        chk("t5_d1", 32'(out_data1), 32'h0);
        chk("t5_d2", 32'(out_data2), 32'h0);
        chk("t5_d3", 32'(out_data3), 32'h0);
        chk("t5_cnt", 32'(accept_cnt), 32'h0);
        chk("t5_ready", 32'(in_ready), 32'h1);

        out_ready = 4'b1111;
        for (int k = 0; k < 4; k++) exp_data[k] = 16'h0;
        for (int i = 0; i < 17; i++) begin
            put(1'b1, 2'(i % 4), 16'h100 + 16'(i));
            exp_data[i % 4] = 16'h100 + 16'(i);
            tick();
            chk("t6_valid_bit", 32'(out_valid[i % 4]), 32'h1);
            chk("t6_data", 32'(od(i % 4)), 32'(exp_data[i % 4]));
            chk("t6_cnt", 32'(accept_cnt), 32'((i + 1) % 16));
        end
        put(1'b0, 2'd0, 16'h0);
        tick();
        chk("t6_wrap_cnt", 32'(accept_cnt), 32'h1);
        chk("t6_idle_valid", 32'(out_valid), 32'h0);
        for (int k = 0; k < 4; k++) chk("t6_sb", 32'(od(k)), 32'(exp_data[k]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
